// File: rtl/edge_bounce_controller.sv
// Frame-rate bounce controller: gathers hit edges per frame, reflects speed, advances a clamped fixed-point position.
// Optional feature macro: GRAVITY_EN (adds saturating downward acceleration to the Y speed).
module edge_bounce_controller #(
  parameter int INIT_X       = 280,
  parameter int INIT_Y       = 185,
  parameter int INIT_SPEED_X = 60,
  parameter int INIT_SPEED_Y = 40,
  parameter int FIXED_SHIFT  = 6,
  parameter int X_MAX        = 607,
  parameter int Y_MAX        = 447
`ifdef GRAVITY_EN
  ,parameter int GRAVITY     = 2,
  parameter int MAX_SPEED_Y  = 400
`endif
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               collision,
  input  logic [3:0]         HitEdgeCode,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               bounceEvent,
  output logic [3:0]         frameHits
);

  localparam logic signed [16:0] POS_X_INIT = 17'(INIT_X * (1 << FIXED_SHIFT));
  localparam logic signed [16:0] POS_Y_INIT = 17'(INIT_Y * (1 << FIXED_SHIFT));
  localparam logic signed [17:0] POS_X_MAX  = 18'(X_MAX * (1 << FIXED_SHIFT));
  localparam logic signed [17:0] POS_Y_MAX  = 18'(Y_MAX * (1 << FIXED_SHIFT));
  localparam logic signed [10:0] SPD_X_INIT = 11'(INIT_SPEED_X);
  localparam logic signed [10:0] SPD_Y_INIT = 11'(INIT_SPEED_Y);

  typedef enum logic [1:0] {ACCUM, SPEED, POS} state_t;

  state_t             r_state, w_state_next;
  logic [3:0]         r_acc, r_frame_hits;
  logic signed [16:0] r_pos_x, r_pos_y;
  logic signed [10:0] r_speed_x, r_speed_y;
  logic signed [10:0] r_tl_x, r_tl_y;
  logic               r_bounce;

  logic               w_flip_x, w_flip_y;
  logic signed [17:0] w_sum_x, w_sum_y;
  logic signed [16:0] w_pos_x_next, w_pos_y_next;
  logic signed [10:0] w_speed_y_pos;

  // Negating the most negative speed would wrap, so it pins to the largest positive value.
  function automatic logic signed [10:0] neg_sat(input logic signed [10:0] v);
    if (v == 11'sh400) return 11'sh3FF;
    return -v;
  endfunction

  function automatic logic signed [16:0] clamp_pos(input logic signed [17:0] v,
                                                    input logic signed [17:0] vmax);
    if (v < 0) return '0;
    if (v > vmax) return vmax[16:0];
    return v[16:0];
  endfunction

  // Opposite edges hit in the same frame cancel out and leave the speed alone.
  assign w_flip_x = (r_frame_hits[3] && !r_frame_hits[1] && (r_speed_x < 0)) ||
                    (r_frame_hits[1] && !r_frame_hits[3] && (r_speed_x > 0));
  assign w_flip_y = (r_frame_hits[2] && !r_frame_hits[0] && (r_speed_y < 0)) ||
                    (r_frame_hits[0] && !r_frame_hits[2] && (r_speed_y > 0));

  assign w_sum_x = $signed({r_pos_x[16], r_pos_x}) + $signed({{7{r_speed_x[10]}}, r_speed_x});
  assign w_sum_y = $signed({r_pos_y[16], r_pos_y}) + $signed({{7{r_speed_y[10]}}, r_speed_y});
  assign w_pos_x_next = clamp_pos(w_sum_x, POS_X_MAX);
  assign w_pos_y_next = clamp_pos(w_sum_y, POS_Y_MAX);

`ifdef GRAVITY_EN
  localparam logic signed [11:0] GRAV_STEP  = 12'(GRAVITY);
  localparam logic signed [11:0] SPD_Y_CAP  = 12'(MAX_SPEED_Y);
  localparam logic signed [10:0] SPD_Y_SAT  = 11'(MAX_SPEED_Y);
  logic signed [11:0] w_grav_sum;
  assign w_grav_sum    = $signed({r_speed_y[10], r_speed_y}) + GRAV_STEP;
  assign w_speed_y_pos = (w_grav_sum > SPD_Y_CAP) ? SPD_Y_SAT : w_grav_sum[10:0];
`else
  assign w_speed_y_pos = r_speed_y;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= ACCUM;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM:   if (startOfFrame) w_state_next = SPEED;
      SPEED:   w_state_next = POS;
      POS:     w_state_next = ACCUM;
      default: w_state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_acc        <= '0;
      r_frame_hits <= '0;
      r_pos_x      <= POS_X_INIT;
      r_pos_y      <= POS_Y_INIT;
      r_speed_x    <= SPD_X_INIT;
      r_speed_y    <= SPD_Y_INIT;
      r_tl_x       <= 11'(INIT_X);
      r_tl_y       <= 11'(INIT_Y);
      r_bounce     <= 1'b0;
    end else begin
      r_bounce <= 1'b0;
      // A hit arriving with the frame pulse belongs to the frame that is just starting.
      if (r_state == ACCUM && startOfFrame) begin
        r_frame_hits <= r_acc;
        r_acc        <= collision ? HitEdgeCode : 4'b0000;
      end else if (collision) begin
        r_acc <= r_acc | HitEdgeCode;
      end
      if (r_state == SPEED) begin
        if (w_flip_x) r_speed_x <= neg_sat(r_speed_x);
        if (w_flip_y) r_speed_y <= neg_sat(r_speed_y);
        r_bounce <= w_flip_x || w_flip_y;
      end
      if (r_state == POS) begin
        r_pos_x   <= w_pos_x_next;
        r_pos_y   <= w_pos_y_next;
        r_tl_x    <= w_pos_x_next[FIXED_SHIFT +: 11];
        r_tl_y    <= w_pos_y_next[FIXED_SHIFT +: 11];
        r_speed_y <= w_speed_y_pos;
      end
    end
  end

  assign topLeftX    = r_tl_x;
  assign topLeftY    = r_tl_y;
  assign bounceEvent = r_bounce;
  assign frameHits   = r_frame_hits;

endmodule
